byte_lane_data_memory: RTL and testbench
========================================

Name: byte_lane_data_memory

Overview:
Clocked, byte-addressed, single-port data memory for the MIPS datapath. It replaces the combinational load/store memory with:
- synchronous writes using byte-lane enables
- a registered read with a valid strobe
- signed and unsigned sub-word loads
- misalignment detection
- a hardware zero-initialisation sweep after reset

Width, depth and endianness are parameters.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, at least 32; LANES = DATA_WIDTH/8.
MEMORY_SIZE, 512, capacity in bytes; power of two; multiple of LANES.
BIG_ENDIAN, 1, 1 = byte at lowest address is MSB of word; 0 = LSB.
ADDR_WIDTH, $clog2(MEMORY_SIZE), localparam, byte-address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  memory can accept a request this cycle.
wr_en  in  1  1 = store, 0 = load; sampled on accept.
addr  in  ADDR_WIDTH  byte address.
access_type  in  2  00 byte, 01 halfword, 11 full word, 10 full word.
unsigned_ld  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
din  in  DATA_WIDTH  store data; right-justified for byte/half.
dout  out  DATA_WIDTH  load result.
rvalid  out  1  one-cycle strobe: dout valid.
misalign_err  out  1  one-cycle strobe: the previous accepted request was misaligned.
init_done  out  1  high once the init sweep completes.

Behaviour:
- Storage: MEMORY_SIZE/LANES words × DATA_WIDTH bits. Word index = addr[ADDR_WIDTH-1:log2(LANES)]; lane = low bits.
- Reset (async, rst_n=0):
  - req_ready=0, rvalid=0, misalign_err=0, dout=0, init_done=0.
  - state=INIT, sweep counter=0.
  - Memory contents are not touched asynchronously.
- FSM states are INIT and RUN.
- INIT:
  - Each cycle writes zero to word[counter] and increments the counter. req_ready=0.
  - After the last word is written, the next state is RUN with init_done=1.
  - The sweep takes exactly MEMORY_SIZE/LANES cycles after rst_n rises.
- RUN:
  - req_ready=1 every cycle. Accept = req_valid & req_ready.
  - No back-pressure; one request per cycle sustained.
- Alignment on accept:
  - Halfword needs addr[0]=0.
  - Word needs addr[log2(LANES)-1:0]=0.
  - Byte is always aligned.
  - Halfword may sit at any even lane.
- Aligned store:
  - Written at the accepting edge, byte lanes only; other lanes are unchanged.
  - Lane mapping follows BIG_ENDIAN.
  - No rvalid is produced.
- Aligned load:
  - Array is read at the accepting edge. dout and rvalid=1 are registered and visible the following cycle. Latency 1.
  - Byte/half results go in the low bits. The upper bits are the replicated MSB of the loaded field if unsigned_ld=0, else zero.
- Misaligned request:
  - Memory is unchanged.
  - misalign_err=1 in the following cycle.
  - For loads, rvalid=1 also fires with dout=0.
- Read-after-write: a load accepted in the cycle after a store to the same address returns the new data. No same-cycle forwarding is needed, since it is single-port.
- dout holds its last value until the next load response. rvalid and misalign_err are single-cycle pulses.
- Requests presented while req_ready=0 are ignored, with no side effects.
- rst_n asserted mid-INIT or mid-RUN: outputs clear immediately. Any pending response strobe is dropped. The sweep restarts from word 0.
- The address range is covered exactly by ADDR_WIDTH, so no out-of-range case exists.

Test Plan:
1. Release reset → req_ready=0 and init_done=0 for exactly 128 cycles (default params), then both =1. Word load at 0x1FC → dout=0x00000000.
2. Word store 0xDEADBEEF @0x010, then byte load @0x010 signed → next cycle rvalid=1, dout=0xFFFFFFDE. Byte load @0x013 unsigned_ld=1 → dout=0x000000EF.
3. Half store 0x8001 @0x022 over word 0x11223344 @0x020 → word load @0x020 = 0x11228001. Signed half load @0x022 = 0xFFFF8001; unsigned = 0x00008001.
4. Word store @0x006 → misalign_err=1 one cycle, memory @0x004 unchanged. Half load @0x005 → rvalid=1, misalign_err=1, dout=0.
5. Back-to-back: cycle N store 0xCAFEF00D @0x040, cycle N+1 word load @0x040 → cycle N+2 dout=0xCAFEF00D. Rerun with BIG_ENDIAN=0 → byte @0x040 = 0x0D.
6. Assert rst_n=0 at sweep cycle 50 and release → full 128-cycle sweep repeats, outputs cleared during reset, and earlier-written data reads 0.

Source files
------------

// File: rtl/byte_lane_data_memory.sv
// byte_lane_data_memory
//   Clocked, byte-addressed, single-port data memory. Stores are written with
//   byte-lane enables. Loads are registered: dout/rvalid appear one cycle after
//   accept, with sign or zero extension of byte/halfword results. Misaligned
//   requests are dropped and flagged. After reset, a hardware sweep writes zero
//   to every word before requests are accepted.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    memory accepts a request this cycle (high in RUN)
//   wr_en        1 = store, 0 = load
//   addr         byte address
//   access_type  00 byte, 01 halfword, 1x full word
//   unsigned_ld  1 = zero-extend sub-word load, 0 = sign-extend
//   din          store data, right-justified for byte/halfword
//   dout         load result, held until the next load response
//   rvalid       one-cycle strobe: dout valid
//   misalign_err one-cycle strobe: previous accepted request was misaligned
//   init_done    zero-initialisation sweep complete
//
// state   | meaning
// ST_INIT | sweeping zero into word[sweep_cnt], requests ignored
// ST_RUN  | accepting one request per cycle
module byte_lane_data_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEMORY_SIZE = 512,
    parameter bit BIG_ENDIAN  = 1'b1,
    localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            access_type,
    input  logic                  unsigned_ld,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rvalid,
    output logic                  misalign_err,
    output logic                  init_done
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int WORDS     = MEMORY_SIZE / LANES;
    localparam int WORD_BITS = $clog2(WORDS);
    localparam int SH_W      = $clog2(DATA_WIDTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state, state_nx;
    logic [WORD_BITS-1:0]  sweep_cnt, sweep_cnt_nx;
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  accept, misaligned, store_ok, load_acc;
    logic [WORD_BITS-1:0]  word_idx;
    logic [LANE_BITS-1:0]  lane;
    logic [SH_W-1:0]       lane_sh, pos_byte, pos_half;
    logic [DATA_WIDTH-1:0] wr_mask, wr_data, rd_word, load_val;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    assign word_idx = addr[ADDR_WIDTH-1:LANE_BITS];
    assign lane     = addr[LANE_BITS-1:0];
    assign accept   = req_valid & req_ready;
    assign store_ok = accept & wr_en & ~misaligned;
    assign load_acc = accept & ~wr_en;
    assign rd_word  = mem[word_idx];

    always_comb begin
        state_nx     = state;
        sweep_cnt_nx = sweep_cnt;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_cnt_nx = sweep_cnt + 1'b1;
                if (sweep_cnt == WORD_BITS'(WORDS - 1)) state_nx = ST_RUN;
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // Bit offset of the addressed field inside the word. Big-endian puts the
    // lowest-addressed byte at the top, so offsets count down from the MSB.
    always_comb begin
        lane_sh  = SH_W'({lane, 3'b000});
        pos_byte = BIG_ENDIAN ? SH_W'(DATA_WIDTH - 8)  - lane_sh : lane_sh;
        pos_half = BIG_ENDIAN ? SH_W'(DATA_WIDTH - 16) - lane_sh : lane_sh;
    end

    always_comb begin
        misaligned = 1'b0;
        case (access_type)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = |lane;
        endcase
    end

    always_comb begin
        wr_mask = '1;
        wr_data = din;
        case (access_type)
            2'b00: begin
                wr_mask = DATA_WIDTH'(8'hFF) << pos_byte;
                wr_data = DATA_WIDTH'(din[7:0]) << pos_byte;
            end
            2'b01: begin
                wr_mask = DATA_WIDTH'(16'hFFFF) << pos_half;
                wr_data = DATA_WIDTH'(din[15:0]) << pos_half;
            end
            default: begin
                wr_mask = '1;
                wr_data = din;
            end
        endcase
    end

    always_comb begin
        rd_byte  = 8'(rd_word >> pos_byte);
        rd_half  = 16'(rd_word >> pos_half);
        load_val = rd_word;
        case (access_type)
            2'b00: load_val = unsigned_ld ? DATA_WIDTH'(rd_byte)
                                          : {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            2'b01: load_val = unsigned_ld ? DATA_WIDTH'(rd_half)
                                          : {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // The array has no reset; the sweep clears it synchronously instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (store_ok) begin
            mem[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            sweep_cnt    <= '0;
            rvalid       <= 1'b0;
            misalign_err <= 1'b0;
            dout         <= '0;
        end else begin
            state        <= state_nx;
            sweep_cnt    <= sweep_cnt_nx;
            rvalid       <= load_acc;
            misalign_err <= accept & misaligned;
            if (load_acc) dout <= misaligned ? '0 : load_val;
        end
    end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
module tb_byte_lane_data_memory;

    logic        clk, rst_n, req_valid, wr_en, unsigned_ld;
    logic [8:0]  addr;
    logic [1:0]  access_type;
    logic [31:0] din;
    logic [1:0]  ready, rvalid, mis, idone;
    logic [31:0] dout [2];

    int n_checks = 0;
    int n_fail   = 0;

    // index 0: big-endian instance, index 1: little-endian instance
    logic [7:0]  mref [2][512];
    logic [31:0] exp_dout [2];

    byte_lane_data_memory #(.DATA_WIDTH(32), .MEMORY_SIZE(512), .BIG_ENDIAN(1'b1)) u_dut_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
        .wr_en(wr_en), .addr(addr), .access_type(access_type), .unsigned_ld(unsigned_ld),
        .din(din), .dout(dout[0]), .rvalid(rvalid[0]), .misalign_err(mis[0]),
        .init_done(idone[0]));

    byte_lane_data_memory #(.DATA_WIDTH(32), .MEMORY_SIZE(512), .BIG_ENDIAN(1'b0)) u_dut_le (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
        .wr_en(wr_en), .addr(addr), .access_type(access_type), .unsigned_ld(unsigned_ld),
        .din(din), .dout(dout[1]), .rvalid(rvalid[1]), .misalign_err(mis[1]),
        .init_done(idone[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] at);
        return (at == 2'b00) ? 1 : (at == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [8:0] a, input logic [1:0] at);
        return (at == 2'b01 && a[0]) || (at[1] && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input int k, input logic [8:0] a,
                                           input logic [1:0] at, input bit uns);
        int n = nbytes(at);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b = mref[k][9'(a + 9'(i))];
            if (k == 0) v = (v << 8) | 32'(b);
            else        v = v | (32'(b) << (8 * i));
        end
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input int k, input logic [8:0] a, input logic [1:0] at,
                           input logic [31:0] d);
        int n = nbytes(at);
        for (int i = 0; i < n; i++) begin
            if (k == 0) mref[k][9'(a + 9'(i))] = 8'(d >> (8 * (n - 1 - i)));
            else        mref[k][9'(a + 9'(i))] = 8'(d >> (8 * i));
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 512; i++) mref[k][i] = 8'h00;
    endtask

    // Drives one request starting at a negedge, checks its response at the
    // following negedge, and leaves the bus idle (next call may re-drive at once).
    task automatic issue(input bit we, input logic [8:0] a, input logic [1:0] at,
                         input bit uns, input logic [31:0] d);
        bit m;
        req_valid = 1'b1; wr_en = we; addr = a; access_type = at;
        unsigned_ld = uns; din = d;
        m = m_misaligned(a, at);
        for (int k = 0; k < 2; k++) begin
            if (!we)    exp_dout[k] = m ? 32'h0 : m_load(k, a, at, uns);
            else if (!m) m_store(k, a, at, d);
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rvalid[%0d] we=%0d a=%03h t=%0d", k, we, a, at), 32'(rvalid[k]), 32'(!we));
            chk($sformatf("misalign[%0d] we=%0d a=%03h t=%0d", k, we, a, at), 32'(mis[k]), 32'(m));
            chk($sformatf("dout[%0d] we=%0d a=%03h t=%0d u=%0d", k, we, a, at, uns), dout[k], exp_dout[k]);
        end
        req_valid = 1'b0;
    endtask

    // Holds an ignored store on the bus during the sweep and counts cycles
    // until req_ready rises.
    task automatic wait_sweep(output int cyc);
        req_valid = 1'b1; wr_en = 1'b1; addr = 9'h1FC; access_type = 2'b11;
        din = 32'hFFFF_FFFF;
        cyc = 0;
        while (!ready[0] && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            chk("init_rvalid", 32'(rvalid), 32'h0);
            chk("init_ready_match", 32'(ready[1]), 32'(ready[0]));
        end
        req_valid = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s ready[%0d]", tag, k), 32'(ready[k]), 32'h0);
            chk($sformatf("%s init_done[%0d]", tag, k), 32'(idone[k]), 32'h0);
            chk($sformatf("%s rvalid[%0d]", tag, k), 32'(rvalid[k]), 32'h0);
            chk($sformatf("%s misalign[%0d]", tag, k), 32'(mis[k]), 32'h0);
            chk($sformatf("%s dout[%0d]", tag, k), dout[k], 32'h0);
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; req_valid = 1'b0; wr_en = 1'b0; addr = '0;
        access_type = 2'b00; unsigned_ld = 1'b0; din = '0;
        exp_dout[0] = 32'h0; exp_dout[1] = 32'h0;
        m_clear();
        repeat (3) @(negedge clk);
        chk_cleared("reset");

        // 1: sweep length and zeroed memory
        rst_n = 1'b1;
        wait_sweep(cyc);
        chk("sweep_len", 32'(cyc), 32'd128);
        chk("init_done_be", 32'(idone[0]), 32'h1);
        chk("init_done_le", 32'(idone[1]), 32'h1);
        issue(1'b0, 9'h1FC, 2'b11, 1'b0, 32'h0);
        chk("t1_zero", dout[0], 32'h0000_0000);

        // 2: word store, signed/unsigned byte loads
        issue(1'b1, 9'h010, 2'b11, 1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 9'h010, 2'b00, 1'b0, 32'h0);
        chk("t2_sbyte", dout[0], 32'hFFFF_FFDE);
        issue(1'b0, 9'h013, 2'b00, 1'b1, 32'h0);
        chk("t2_ubyte", dout[0], 32'h0000_00EF);

        // 3: halfword merge and half loads
        issue(1'b1, 9'h020, 2'b10, 1'b0, 32'h1122_3344);
        issue(1'b1, 9'h022, 2'b01, 1'b0, 32'h0000_8001);
        issue(1'b0, 9'h020, 2'b11, 1'b0, 32'h0);
        chk("t3_word", dout[0], 32'h1122_8001);
        issue(1'b0, 9'h022, 2'b01, 1'b0, 32'h0);
        chk("t3_shalf", dout[0], 32'hFFFF_8001);
        issue(1'b0, 9'h022, 2'b01, 1'b1, 32'h0);
        chk("t3_uhalf", dout[0], 32'h0000_8001);

        // 4: misaligned store and load
        issue(1'b1, 9'h004, 2'b11, 1'b0, 32'h5555_AAAA);
        issue(1'b1, 9'h006, 2'b11, 1'b0, 32'h1234_5678);
        issue(1'b0, 9'h004, 2'b11, 1'b0, 32'h0);
        chk("t4_unchanged", dout[0], 32'h5555_AAAA);
        issue(1'b0, 9'h005, 2'b01, 1'b0, 32'h0);
        chk("t4_mis_dout", dout[0], 32'h0);

        // 5: back-to-back store then load, both endiannesses
        issue(1'b1, 9'h040, 2'b11, 1'b0, 32'hCAFE_F00D);
        issue(1'b0, 9'h040, 2'b11, 1'b0, 32'h0);
        chk("t5_raw", dout[0], 32'hCAFE_F00D);
        issue(1'b0, 9'h040, 2'b00, 1'b1, 32'h0);
        chk("t5_le_byte", dout[1], 32'h0000_000D);
        chk("t5_be_byte", dout[0], 32'h0000_00CA);

        // randomized traffic in a small window so loads hit earlier stores
        for (int i = 0; i < 250; i++) begin
            issue(1'($urandom_range(0, 1)), 9'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        // 6: reset mid-RUN drops a pending strobe, then reset mid-sweep
        issue(1'b0, 9'h040, 2'b11, 1'b0, 32'h0);
        req_valid = 1'b1; wr_en = 1'b0; addr = 9'h040; access_type = 2'b11;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_cleared("run_reset");
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_cleared("sweep_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        exp_dout[0] = 32'h0; exp_dout[1] = 32'h0;
        wait_sweep(cyc);
        chk("resweep_len", 32'(cyc), 32'd128);
        issue(1'b0, 9'h040, 2'b11, 1'b0, 32'h0);
        chk("t6_cleared_40", dout[0], 32'h0);
        issue(1'b0, 9'h010, 2'b11, 1'b0, 32'h0);
        chk("t6_cleared_10", dout[1], 32'h0);
        issue(1'b0, 9'h020, 2'b01, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
